router_rx_port: RTL and testbench
=================================

Name: router_rx_port

Overview:
- Downstream consumer of one router output port (data_out_N / valid_out_N / read_enb_N).
- Pops bytes from the port FIFO and parses each packet: header {len[7:2], addr[1:0]}, then len payload bytes, then one parity byte.
- Checks parity (XOR of header and all payload bytes) and address, streams the payload out, and reports per-packet status.
- One instance per router output port. Used as the sink model in system benches and as the synthesizable egress stage.

Parameters:
- PORT_ID, 0, expected 2-bit destination address for this port.
- READ_DELAY, 2, idle cycles between seeing valid_out and asserting the first read_enb of a packet; legal range 0..25. Keeps the router's 30-cycle FIFO soft-reset from firing.
- TIMEOUT, 40, cycles without a captured byte mid-packet before the packet is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_out  in  1  router port FIFO not empty.
- data_out  in  8  router FIFO read data; valid one cycle after a read_enb edge.
- read_enb  out  1  FIFO pop request.
- pl_data  out  8  captured payload byte.
- pl_valid  out  1  pl_data valid; one-cycle pulse per payload byte.
- pkt_done  out  1  one-cycle pulse after the parity byte is captured.
- pkt_err  out  1  parity mismatch; valid with pkt_done.
- addr_err  out  1  header addr != PORT_ID; valid with pkt_done.
- pkt_abort  out  1  one-cycle pulse when a packet is abandoned on timeout.
- rx_len  out  6  length field of the last header; held until the next header.
- rx_cnt  out  16  packets completed (RX_STATS_EN only).
- err_cnt  out  16  packets completed with pkt_err or addr_err (RX_STATS_EN only).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs and counters 0; internal parity accumulator 0.
- Read latency: a byte requested by read_enb=1 at edge k appears on data_out and is captured at edge k+1. A registered flag rd_q marks capture cycles.
- read_enb is registered and is 1 only when all of the following hold:
  - valid_out=1;
  - state is HDR_REQ or BODY;
  - requested bytes < needed bytes.
  Reads are never issued beyond the current packet.
- IDLE: when valid_out=1, go to WAIT and load the delay counter with READ_DELAY.
- WAIT: count down; at 0, go to HDR_REQ.
- HDR_REQ: issue exactly one read, then go to HDR_CAP.
- HDR_CAP: on capture:
  - rx_len <= data[7:2]; store addr; parity <= data;
  - needed bytes = len+1; go to BODY.
- BODY: issue reads while allowed. Each captured byte:
  - bytes 1..len: XOR into parity; drive pl_data and pl_valid.
  - byte len+1 (parity): compare with the accumulator. Next cycle, pulse pkt_done with pkt_err = mismatch and addr_err = (addr != PORT_ID). Go to IDLE.
- len=0: parity byte immediately follows the header; no pl_valid pulses.
- valid_out falling mid-packet (FIFO drained while the router is still writing): drop read_enb, stay in state, resume when valid_out returns. A read already in flight is still captured.
- Timeout: a counter resets on every capture and counts in HDR_CAP/BODY. At TIMEOUT: pulse pkt_abort, clear read_enb, go to IDLE. No pkt_done is produced. This covers a router soft-reset flushing a partial packet.
- Back-to-back packets: a new packet is handled through IDLE/WAIT/HDR_REQ, at minimum READ_DELAY+3 cycles after pkt_done.
- Simultaneous events: pkt_done and a new valid_out in the same cycle means IDLE sees valid_out on the next cycle. Reset overrides everything.

Optional Feature:
- RX_STATS_EN defined:
  - rx_cnt increments on each pkt_done;
  - err_cnt increments on pkt_done when pkt_err|addr_err;
  - both saturate at 16'hFFFF and are not cleared by pkt_abort.
- RX_STATS_EN undefined: rx_cnt and err_cnt are tied to 0; the port list is unchanged.

Decomposition:
- Package router_pkg holds:
  - LEN_W=6, ADDR_W=2;
  - SOFT_RST_LIMIT=30;
  - the state enum IDLE/WAIT/HDR_REQ/HDR_CAP/BODY.
- One sub-module, router_rx_parity: clear/load/accumulate XOR register with a compare output, instantiated once.

Test Plan:
- Header 0x19 (len 6, addr 1), payload 0x11..0x16, parity 0x1E, PORT_ID=1 -> six pl_valid pulses with 0x11..0x16 in order, pkt_done=1, pkt_err=0, addr_err=0, rx_len=6.
- Same packet with parity byte 0x1F -> pkt_done with pkt_err=1; err_cnt=1 under RX_STATS_EN.
- Header 0x01 (len 0, addr 1), parity 0x01 -> no pl_valid, pkt_done with pkt_err=0; exactly 2 read_enb cycles.
- Header 0x1A (addr 2) at PORT_ID=1 with correct parity -> addr_err=1, pkt_err=0.
- valid_out held low for 10 cycles after payload byte 3, then resumed -> read_enb drops, no byte lost or duplicated, packet completes clean. Holding valid_out low for 41 cycles instead -> pkt_abort pulse, return to IDLE, no pkt_done.
- Assert reset mid-BODY -> all outputs 0 immediately, read_enb 0. The next full packet is received correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router egress (rx) port.
package router_pkg;

    localparam int LEN_W          = 6;
    localparam int ADDR_W         = 2;
    // Router FIFO soft-resets after this many cycles without a read.
    localparam int SOFT_RST_LIMIT = 30;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        HDR_REQ,
        HDR_CAP,
        BODY
    } rx_state_t;

endpackage

// File: rtl/router_rx_parity.sv
// Running XOR parity register: clear, load with the header byte,
// accumulate payload bytes, and compare against an incoming parity byte.
module router_rx_parity
    import router_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] din,
    output logic              match
);

    logic [DATA_W-1:0] acc_q, acc_d;

    // next accumulator value: clear wins over load, load wins over accumulate
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = din;
        end else if (acc_en) begin
            acc_d = acc_q ^ din;
        end
    end

    // accumulator register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign match = (acc_q == din);

endmodule

// File: rtl/router_rx_port.sv
// Egress consumer for one router output port: pops the port FIFO, parses
// header / payload / parity, streams payload bytes and reports per-packet
// status. Define RX_STATS_EN to enable the saturating rx_cnt / err_cnt
// counters; otherwise both outputs are tied to zero.
module router_rx_port
    import router_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int READ_DELAY = 2,
    parameter int TIMEOUT    = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic        addr_err,
    output logic        pkt_abort,
    output logic [5:0]  rx_len,
    output logic [15:0] rx_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [ADDR_W-1:0] MY_ADDR  = ADDR_W'(PORT_ID);
    localparam logic [4:0]        DLY_INIT = 5'(READ_DELAY);
    localparam logic [15:0]       TO_LIM   = 16'(TIMEOUT);

    rx_state_t         state_q, state_d;
    logic [4:0]        dly_q, dly_d;
    logic [6:0]        req_q, req_d;      // reads issued in the current phase
    logic [6:0]        need_q, need_d;    // bytes the current phase needs
    logic [6:0]        cap_q, cap_d;      // body bytes captured so far
    logic [15:0]       to_q, to_d;        // cycles since last capture
    logic              read_enb_q, read_enb_d;
    logic              rd_q;              // data_out holds a requested byte
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rx_len_q, rx_len_d;
    logic [7:0]        pl_data_q, pl_data_d;
    logic              pl_valid_q, pl_valid_d;
    logic              pkt_done_q, pkt_done_d;
    logic              pkt_err_q, pkt_err_d;
    logic              addr_err_q, addr_err_d;
    logic              pkt_abort_q, pkt_abort_d;
    logic              par_clr, par_load, par_acc, par_match;

    router_rx_parity #(.DATA_W(8)) u_parity (
        .clk    (clk),
        .reset  (reset),
        .clr    (par_clr),
        .load   (par_load),
        .acc_en (par_acc),
        .din    (data_out),
        .match  (par_match)
    );

    // packet parser: next state, read requests, capture and status pulses
    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        req_d       = req_q;
        need_d      = need_q;
        cap_d       = cap_q;
        to_d        = to_q;
        addr_d      = addr_q;
        rx_len_d    = rx_len_q;
        pl_data_d   = pl_data_q;
        pl_valid_d  = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_err_d   = 1'b0;
        addr_err_d  = 1'b0;
        pkt_abort_d = 1'b0;
        read_enb_d  = 1'b0;
        par_clr     = 1'b0;
        par_load    = 1'b0;
        par_acc     = 1'b0;

        case (state_q)
            IDLE: begin
                req_d   = '0;
                cap_d   = '0;
                need_d  = 7'd1;
                to_d    = '0;
                par_clr = 1'b1;
                if (valid_out) begin
                    state_d = WAIT;
                    dly_d   = DLY_INIT;
                end
            end

            WAIT: begin
                if (dly_q == 5'd0) begin
                    state_d = HDR_REQ;
                end else begin
                    dly_d = dly_q - 5'd1;
                end
            end

            HDR_REQ: begin
                if (valid_out && (req_q < need_q)) begin
                    read_enb_d = 1'b1;
                    req_d      = req_q + 7'd1;
                    state_d    = HDR_CAP;
                end
            end

            HDR_CAP: begin
                if (rd_q) begin
                    rx_len_d = data_out[7:2];
                    addr_d   = data_out[1:0];
                    par_load = 1'b1;
                    need_d   = 7'(data_out[7:2]) + 7'd1;
                    req_d    = '0;
                    cap_d    = '0;
                    to_d     = '0;
                    state_d  = BODY;
                end else if (to_q >= TO_LIM) begin
                    pkt_abort_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end

            BODY: begin
                if (valid_out && (req_q < need_q)) begin
                    read_enb_d = 1'b1;
                    req_d      = req_q + 7'd1;
                end
                if (rd_q) begin
                    to_d  = '0;
                    cap_d = cap_q + 7'd1;
                    if (cap_q == need_q - 7'd1) begin
                        // trailing parity byte closes the packet
                        pkt_done_d = 1'b1;
                        pkt_err_d  = ~par_match;
                        addr_err_d = (addr_q != MY_ADDR);
                        read_enb_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        par_acc    = 1'b1;
                        pl_data_d  = data_out;
                        pl_valid_d = 1'b1;
                    end
                end else if (to_q >= TO_LIM) begin
                    pkt_abort_d = 1'b1;
                    read_enb_d  = 1'b0;
                    state_d     = IDLE;
                end else begin
                    to_d = to_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dly_q       <= '0;
            req_q       <= '0;
            need_q      <= '0;
            cap_q       <= '0;
            to_q        <= '0;
            read_enb_q  <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            rx_len_q    <= '0;
            pl_data_q   <= '0;
            pl_valid_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
            pkt_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            req_q       <= req_d;
            need_q      <= need_d;
            cap_q       <= cap_d;
            to_q        <= to_d;
            read_enb_q  <= read_enb_d;
            rd_q        <= read_enb_q;
            addr_q      <= addr_d;
            rx_len_q    <= rx_len_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pkt_done_q  <= pkt_done_d;
            pkt_err_q   <= pkt_err_d;
            addr_err_q  <= addr_err_d;
            pkt_abort_q <= pkt_abort_d;
        end
    end

    assign read_enb  = read_enb_q;
    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_err   = pkt_err_q;
    assign addr_err  = addr_err_q;
    assign pkt_abort = pkt_abort_q;
    assign rx_len    = rx_len_q;

`ifdef RX_STATS_EN
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // saturating counters, updated on the same edge that raises pkt_done
    always_comb begin
        rx_cnt_d  = rx_cnt_q;
        err_cnt_d = err_cnt_q;
        if (pkt_done_d && (rx_cnt_q != 16'hFFFF)) begin
            rx_cnt_d = rx_cnt_q + 16'd1;
        end
        if (pkt_done_d && (pkt_err_d || addr_err_d) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rx_cnt_q  <= rx_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rx_cnt  = rx_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign rx_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_rx_port.sv
// Self-checking bench for router_rx_port: a queue-based model of the router
// port FIFO feeds the DUT; expected payload bytes and packet status are
// queued when a packet is loaded and compared as the DUT produces them.
module tb_router_rx_port;

    localparam int PORT_ID    = 1;
    localparam int READ_DELAY = 2;
    localparam int TIMEOUT    = 40;
    localparam logic [1:0] MY_ADDR = 2'(PORT_ID);

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        read_enb;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pkt_done;
    logic        pkt_err;
    logic        addr_err;
    logic        pkt_abort;
    logic [5:0]  rx_len;
    logic [15:0] rx_cnt;
    logic [15:0] err_cnt;

    router_rx_port #(
        .PORT_ID    (PORT_ID),
        .READ_DELAY (READ_DELAY),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_out (valid_out),
        .data_out  (data_out),
        .read_enb  (read_enb),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .addr_err  (addr_err),
        .pkt_abort (pkt_abort),
        .rx_len    (rx_len),
        .rx_cnt    (rx_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic       aerr;
        logic [5:0] len;
    } done_t;

    logic [7:0] fifo[$];
    logic [7:0] exp_pl[$];
    done_t      exp_done[$];
    done_t      d_exp;
    logic       hold;
    int n_chk, n_pass;
    int pl_seen, done_seen, abort_seen, re_cycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // router FIFO model: pops on read_enb, data valid the following cycle
    always @(posedge clk) begin
        if (read_enb && (fifo.size() != 0)) begin
            data_out <= fifo.pop_front();
        end
    end

    // monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            if (read_enb) re_cycles++;
            if (pl_valid) begin
                pl_seen++;
                if (exp_pl.size() == 0) check_eq("pl_unexpected", 1, 0);
                else check_eq("pl_data", pl_data, exp_pl.pop_front());
            end
            if (pkt_done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    check_eq("done_unexpected", 1, 0);
                end else begin
                    d_exp = exp_done.pop_front();
                    check_eq("pkt_err", pkt_err, d_exp.err);
                    check_eq("addr_err", addr_err, d_exp.aerr);
                    check_eq("rx_len", rx_len, d_exp.len);
                end
            end
            if (pkt_abort) begin
                abort_seen++;
                fifo.delete();     // router soft-reset flushes the partial packet
                exp_pl.delete();
            end
        end
        valid_out = (fifo.size() != 0) && !hold;
    end

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] first,
                            input bit bad_par, input bit expect_done);
        logic [7:0] par;
        logic [7:0] b;
        int len;
        len = int'(hdr[7:2]);
        par = hdr;
        fifo.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = first + 8'(i);
            fifo.push_back(b);
            exp_pl.push_back(b);
            par = par ^ b;
        end
        fifo.push_back(bad_par ? (par ^ 8'h01) : par);
        if (expect_done) begin
            exp_done.push_back('{err: bad_par, aerr: (hdr[1:0] != MY_ADDR), len: hdr[7:2]});
        end
    endtask

    task automatic wait_done(input int base, input string tag);
        int t;
        t = 0;
        while ((done_seen == base) && (t < 400)) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq(tag, done_seen, base + 1);
    endtask

    task automatic wait_pl(input int target, input string tag);
        int t;
        t = 0;
        while ((pl_seen < target) && (t < 400)) begin
            @(posedge clk); #1;
            t++;
        end
        if (pl_seen < target) check_eq(tag, pl_seen, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, pls, abs;
        reset = 1'b0; hold = 1'b0; valid_out = 1'b0; data_out = 8'h00;
        n_chk = 0; n_pass = 0; pl_seen = 0; done_seen = 0; abort_seen = 0; re_cycles = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_read_enb", read_enb, 0);
        check_eq("rst_pl_valid", pl_valid, 0);
        check_eq("rst_pkt_done", pkt_done, 0);
        check_eq("rst_pkt_abort", pkt_abort, 0);
        check_eq("rst_rx_len", rx_len, 0);
        check_eq("rst_pl_data", pl_data, 0);
        check_eq("rst_rx_cnt", rx_cnt, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // good packet, len 6, addr 1
        base = done_seen; pls = pl_seen;
        send_pkt(8'h19, 8'h11, 1'b0, 1'b1);
        wait_done(base, "t1_done");
        repeat (2) @(posedge clk); #1;
        check_eq("t1_pl_count", pl_seen - pls, 6);
        check_eq("t1_rx_len_hold", rx_len, 6);
`ifdef RX_STATS_EN
        check_eq("t1_rx_cnt", rx_cnt, 1);
        check_eq("t1_err_cnt", err_cnt, 0);
`else
        check_eq("t1_rx_cnt_tied", rx_cnt, 0);
`endif

        // same packet with a corrupted parity byte
        base = done_seen;
        send_pkt(8'h19, 8'h11, 1'b1, 1'b1);
        wait_done(base, "t2_done");
        repeat (2) @(posedge clk); #1;
`ifdef RX_STATS_EN
        check_eq("t2_err_cnt", err_cnt, 1);
`else
        check_eq("t2_err_cnt_tied", err_cnt, 0);
`endif

        // zero-length packet: header + parity only
        base = done_seen; pls = pl_seen; re_cycles = 0;
        send_pkt(8'h01, 8'h00, 1'b0, 1'b1);
        wait_done(base, "t3_done");
        repeat (2) @(posedge clk); #1;
        check_eq("t3_read_cycles", re_cycles, 2);
        check_eq("t3_no_payload", pl_seen - pls, 0);
        check_eq("t3_rx_len", rx_len, 0);

        // wrong destination address
        base = done_seen;
        send_pkt(8'h1A, 8'h21, 1'b0, 1'b1);
        wait_done(base, "t4_done");
        repeat (2) @(posedge clk); #1;
`ifdef RX_STATS_EN
        check_eq("t4_rx_cnt", rx_cnt, 4);
        check_eq("t4_err_cnt", err_cnt, 2);
`endif

        // FIFO drains for 10 cycles after payload byte 3
        base = done_seen; pls = pl_seen; abs = abort_seen;
        send_pkt(8'h19, 8'h31, 1'b0, 1'b1);
        wait_pl(pls + 3, "t5_pl3_timeout");
        hold = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t5_read_enb_dropped", read_enb, 0);
        hold = 1'b0;
        wait_done(base, "t5_done");
        repeat (2) @(posedge clk); #1;
        check_eq("t5_pl_count", pl_seen - pls, 6);
        check_eq("t5_no_abort", abort_seen - abs, 0);

        // FIFO drains for 41 cycles: packet abandoned
        base = done_seen; pls = pl_seen; abs = abort_seen;
        send_pkt(8'h19, 8'h41, 1'b0, 1'b0);
        wait_pl(pls + 3, "t6_pl3_timeout");
        hold = 1'b1;
        repeat (41) @(posedge clk);
        #1;
        hold = 1'b0;
        for (int t = 0; (t < 100) && (abort_seen == abs); t++) begin
            @(posedge clk); #1;
        end
        check_eq("t6_abort", abort_seen - abs, 1);
        repeat (20) @(posedge clk); #1;
        check_eq("t6_no_done", done_seen, base);
        check_eq("t6_read_enb_idle", read_enb, 0);

        // reset in the middle of a packet body
        pls = pl_seen;
        send_pkt(8'h19, 8'h51, 1'b0, 1'b1);
        wait_pl(pls + 2, "t7_pl2_timeout");
        reset = 1'b0;
        #1;
        check_eq("t7_rst_read_enb", read_enb, 0);
        check_eq("t7_rst_pl_valid", pl_valid, 0);
        check_eq("t7_rst_rx_len", rx_len, 0);
        check_eq("t7_rst_pl_data", pl_data, 0);
        check_eq("t7_rst_rx_cnt", rx_cnt, 0);
        check_eq("t7_rst_err_cnt", err_cnt, 0);
        fifo.delete(); exp_pl.delete(); exp_done.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        base = done_seen; pls = pl_seen;
        send_pkt(8'h1D, 8'h61, 1'b0, 1'b1);
        wait_done(base, "t7_done");
        repeat (2) @(posedge clk); #1;
        check_eq("t7_pl_count", pl_seen - pls, 7);
`ifdef RX_STATS_EN
        check_eq("t7_rx_cnt", rx_cnt, 1);
`endif
        check_eq("end_exp_pl_empty", exp_pl.size(), 0);
        check_eq("end_exp_done_empty", exp_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
